// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment display path: segment glyphs and the BCD range.
package seg7_pkg;

    typedef logic [6:0] seg_t;  // {g,f,e,d,c,b,a}, active-high

    localparam seg_t SEG_BLANK = 7'b000_0000;
    localparam seg_t GLYPH_0   = 7'h3F;
    localparam seg_t GLYPH_1   = 7'h06;
    localparam seg_t GLYPH_2   = 7'h5B;
    localparam seg_t GLYPH_3   = 7'h4F;
    localparam seg_t GLYPH_4   = 7'h66;
    localparam seg_t GLYPH_5   = 7'h6D;
    localparam seg_t GLYPH_6   = 7'h7D;
    localparam seg_t GLYPH_7   = 7'h07;
    localparam seg_t GLYPH_8   = 7'h7F;
    localparam seg_t GLYPH_9   = 7'h6F;

    localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/seg7_load_if.sv
// Double-buffer load channel: the score counters offer a BCD word, the scan mux accepts it.
interface seg7_load_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    load_valid;
    logic                    load_ready;
    logic [4*NUM_DIGITS-1:0] digits_in;

    modport master (output load_valid, output digits_in, input load_ready);
    modport slave  (input load_valid, input digits_in, output load_ready);
endinterface

// File: rtl/seg7_decoder.sv
// BCD digit to common-cathode segment pattern; non-BCD codes give a dark digit.
module seg7_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] bcd_i,
    output seg_t       seg_o
);
    always_comb begin
        unique case (bcd_i)
            4'd0:    seg_o = GLYPH_0;
            4'd1:    seg_o = GLYPH_1;
            4'd2:    seg_o = GLYPH_2;
            4'd3:    seg_o = GLYPH_3;
            4'd4:    seg_o = GLYPH_4;
            4'd5:    seg_o = GLYPH_5;
            4'd6:    seg_o = GLYPH_6;
            4'd7:    seg_o = GLYPH_7;
            4'd8:    seg_o = GLYPH_8;
            4'd9:    seg_o = GLYPH_9;
            default: seg_o = SEG_BLANK;
        endcase
    end
endmodule

// File: rtl/seg7_slot_timer.sv
// Digit-slot timebase: counts cycles within a slot and steps the scanned digit on wrap.
module seg7_slot_timer #(
    parameter  int NUM_DIGITS = 4,
    parameter  int SCAN_DIV   = 16000,
    localparam int CNT_W      = $clog2(SCAN_DIV),
    localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    output logic [CNT_W-1:0] slot_cnt_o,
    output logic [IDX_W-1:0] scan_idx_o,
    output logic             slot_start_o,
    output logic             frame_wrap_o,
    output logic             frame_first_o
);
    logic [CNT_W-1:0] slot_cnt_q, slot_cnt_d;
    logic [IDX_W-1:0] scan_idx_q, scan_idx_d;
    logic             slot_wrap;

    // NOTE: state registers use non-blocking assignments only; all next-state math lives in
    // the combinational process so the flops never race each other in simulation.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_cnt_q <= '0;
            scan_idx_q <= '0;
        end else begin
            slot_cnt_q <= slot_cnt_d;
            scan_idx_q <= scan_idx_d;
        end
    end

    // NOTE: every output of this process gets a default first, so no path can infer a latch.
    always_comb begin
        slot_wrap     = (slot_cnt_q == CNT_W'(SCAN_DIV - 1));
        frame_wrap_o  = slot_wrap && (scan_idx_q == IDX_W'(NUM_DIGITS - 1));
        slot_start_o  = (slot_cnt_q == '0);
        frame_first_o = slot_start_o && (scan_idx_q == '0);
        slot_cnt_d    = slot_cnt_q + 1'b1;
        scan_idx_d    = scan_idx_q;
        if (slot_wrap) begin
            slot_cnt_d = '0;
            scan_idx_d = frame_wrap_o ? '0 : scan_idx_q + 1'b1;
        end
    end

    assign slot_cnt_o = slot_cnt_q;
    assign scan_idx_o = scan_idx_q;
endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed 7-segment driver: double-buffered BCD load, frame-aligned updates,
// anti-ghost blanking, leading-zero suppression and 16-level PWM brightness.
module seg7_scan_mux
    import seg7_pkg::*;
#(
    parameter  int NUM_DIGITS   = 4,
    parameter  int SCAN_DIV     = 16000,
    parameter  int BLANK_CYCLES = 16,
    localparam int CNT_W        = $clog2(SCAN_DIV),
    localparam int IDX_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    seg7_load_if.slave            load,
    input  logic                  lz_en,
    input  logic [3:0]            brightness,
    output seg_t                  seg_out,
    output logic [NUM_DIGITS-1:0] dig_en,
    output logic                  frame_start
);
    localparam int STEP = (SCAN_DIV - BLANK_CYCLES) / 16;
    localparam logic [NUM_DIGITS-1:0] DIG_ONE = NUM_DIGITS'(1);

    logic [CNT_W-1:0] slot_cnt;
    logic [IDX_W-1:0] scan_idx;
    logic             slot_start, frame_wrap, frame_first;

    logic [4*NUM_DIGITS-1:0] active_q, active_d, pending_q, pending_d;
    logic                    pending_full_q, pending_full_d;
    logic [3:0]              bright_q, bright_d, eff_bright;
    seg_t                    seg_q, seg_d, glyph;
    logic [NUM_DIGITS-1:0]   dig_en_q, dig_en_d;
    logic                    frame_start_q, frame_start_d;
    logic [3:0]              digit;
    logic                    higher_zero, lz_blank, lit;

    seg7_slot_timer #(.NUM_DIGITS(NUM_DIGITS), .SCAN_DIV(SCAN_DIV)) u_timer (
        .clk           (clk),
        .reset         (reset),
        .slot_cnt_o    (slot_cnt),
        .scan_idx_o    (scan_idx),
        .slot_start_o  (slot_start),
        .frame_wrap_o  (frame_wrap),
        .frame_first_o (frame_first)
    );

    assign digit = active_q[{scan_idx, 2'b00} +: 4];

    seg7_decoder u_decoder (.bcd_i(digit), .seg_o(glyph));

    always_comb begin
        // The slot's first cycle sees the live input so the sampled level covers the whole slot.
        eff_bright = slot_start ? brightness : bright_q;
        bright_d   = eff_bright;
        lit = (int'(slot_cnt) >= BLANK_CYCLES) &&
              (int'(slot_cnt) - BLANK_CYCLES < int'(eff_bright) * STEP);

        higher_zero = 1'b1;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if (j > int'(scan_idx) && active_q[4*j +: 4] != 4'd0) higher_zero = 1'b0;
        end
        lz_blank = lz_en && (digit == 4'd0) && (scan_idx != '0) && higher_zero;

        dig_en_d      = '0;
        seg_d         = SEG_BLANK;
        frame_start_d = frame_first;
        if (lit && !lz_blank) begin
            dig_en_d = DIG_ONE << scan_idx;
            seg_d    = glyph;
        end

        // Capture needs an empty pending buffer and transfer needs a full one, so they never overlap.
        active_d       = active_q;
        pending_d      = pending_q;
        pending_full_d = pending_full_q;
        if (frame_wrap && pending_full_q) begin
            active_d       = pending_q;
            pending_full_d = 1'b0;
        end
        if (load.load_valid && !pending_full_q) begin
            pending_d      = load.digits_in;
            pending_full_d = 1'b1;
        end
    end

    // NOTE: both digit buffers are reset as well, so a reset mid-frame drops any queued word
    // and the display restarts from a known all-zero value.
    always_ff @(posedge clk) begin
        if (reset) begin
            active_q       <= '0;
            pending_q      <= '0;
            pending_full_q <= 1'b0;
            bright_q       <= '0;
            seg_q          <= SEG_BLANK;
            dig_en_q       <= '0;
            frame_start_q  <= 1'b0;
        end else begin
            active_q       <= active_d;
            pending_q      <= pending_d;
            pending_full_q <= pending_full_d;
            bright_q       <= bright_d;
            seg_q          <= seg_d;
            dig_en_q       <= dig_en_d;
            frame_start_q  <= frame_start_d;
        end
    end

    assign load.load_ready = !pending_full_q;
    assign seg_out         = seg_q;
    assign dig_en          = dig_en_q;
    assign frame_start     = frame_start_q;

    a_dig_onehot0: assert property (@(posedge clk) disable iff (reset) $onehot0(dig_en));
    a_seg_dark:    assert property (@(posedge clk) disable iff (reset)
                                    (dig_en == '0) |-> (seg_out == SEG_BLANK));
endmodule
